imm_gen_pipe: RTL
=================

# imm_gen_pipe

Pipelined, parametrised immediate generator and branch-target unit for the TinyRV1 decode path. It extracts and sign-extends the I/S/J/B/U immediates to XLEN bits and optionally adds the PC to form a PC-relative target. Results travel through STAGES elastic register stages with a val/rdy handshake, so decode can be retimed and back-pressured by execute. It also flushes on redirect.

## Interface
- XLEN, 32: datapath width for imm/pc/target; legal values are 32 and 64.
- STAGES, 1: number of elastic register stages (1..4); equals the latency.

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous squash of all in-flight entries
- in_val  in  1  input transaction valid
- in_rdy  out  1  block can accept the input this cycle
- inst  in  32  instruction word
- pc  in  XLEN  PC of inst
- imm_type  in  3  0=I, 1=S, 2=J, 3=B, 4=U, 5..7 illegal
- pc_rel  in  1  1: target = pc + imm; 0: target = imm
- out_val  out  1  output valid
- out_rdy  in  1  consumer accepts output
- imm  out  XLEN  sign-extended immediate
- target  out  XLEN  computed target
- err  out  1  illegal imm_type
- misalign  out  1  target[1:0] != 0 for J/B types with pc_rel=1

## Operation
- Immediate formats, sign bit inst[31] replicated to XLEN:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
- Illegal imm_type: imm=0, target = pc_rel ? pc : 0, err=1, misalign=0.
- Target addition is modulo 2^XLEN; wrap-around is silent.
- inst[6:0] is unused.
- imm, target, err and misalign are computed combinationally at the input and carried unchanged through the stages.
- Stages 0..STAGES-1 each hold a valid bit and a payload. Stage k loads when it is empty or stage k+1 loads; for the last stage, "stage k+1 loads" means out_rdy.
  - in_rdy = stage 0 loads, a combinational chain from out_rdy.
  - Bubbles collapse: an empty stage always accepts from the stage before it.
  - Order is strictly FIFO; nothing is duplicated or dropped except on flush or rst.
- flush=1: every stage valid clears on the next edge, and an input handshake in the same cycle is discarded. in_rdy is not masked by flush.
- rst has priority over flush; flush has priority over a load.

## Timing
- Reset: all valids=0, payload registers=0. So out_val=0, imm=0, target=0, err=0, misalign=0.
- Outputs are driven from last-stage registers only.
- Latency: an input accepted at edge t appears at out_val after STAGES edges, if there is no stall.
- Throughput: one transaction per cycle while out_rdy=1.
- With out_rdy=0 held, exactly STAGES entries are accepted, then in_rdy=0.
- When full, out_rdy=1 and in_val=1 in the same cycle give an output handshake and an input handshake together. Occupancy stays full.
- out_val and payload hold stable while out_val=1 and out_rdy=0.
- rst or flush mid-stall: out_val=0 on the next cycle, and in_rdy=1 on that cycle.

## Test plan
- Reset/format, XLEN=32, STAGES=1:
  - I, inst=0xFFF00093 -> imm=0xFFFFFFFF, one cycle later.
  - S, inst=0x0020A423 -> imm=0x00000008.
  - U, inst=0x123450B7 -> imm=0x12345000.
  - All outputs are 0 after rst.
- PC-relative J: inst=0xFFDFF0EF, pc=0x100, pc_rel=1 -> imm=0xFFFFFFFC, target=0x000000FC, misalign=0.
  - Same with pc=0x102 -> misalign=1.
- Wrap and illegal:
  - B with pc=0xFFFFFFFC, imm=+8 -> target=0x00000004.
  - imm_type=6, pc_rel=1, pc=0x40 -> err=1, imm=0, target=0x40.
- Backpressure, STAGES=2: out_rdy=0, offer 3 transactions -> 2 accepted and in_rdy=0. Release out_rdy -> the three emerge in order, one per cycle, with no loss.
- Flush, STAGES=3: fill 3 entries, pulse flush together with an input handshake -> out_val=0 next cycle and the flushed-cycle input never appears. Same check with rst mid-stream.
- XLEN=64: I, inst=0xFFF00093 -> imm=0xFFFFFFFFFFFFFFFF. U with inst[31]=1 sign-extends through bit 63.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if
//   Bundles the decode-side request (in_val/in_rdy plus instruction, PC,
//   immediate type and pc_rel) and the execute-side response
//   (out_val/out_rdy plus imm, target, err, misalign) of imm_gen_pipe.
//   master: the side that issues requests and consumes results.
//   slave : the immediate generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_val;
    logic            in_rdy;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [2:0]      imm_type;
    logic            pc_rel;
    logic            out_val;
    logic            out_rdy;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            err;
    logic            misalign;

    modport master (
        output in_val, inst, pc, imm_type, pc_rel, out_rdy,
        input  in_rdy, out_val, imm, target, err, misalign
    );

    modport slave (
        input  in_val, inst, pc, imm_type, pc_rel, out_rdy,
        output in_rdy, out_val, imm, target, err, misalign
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decodes the I/S/J/B/U immediate of a TinyRV1 instruction, sign-extends
//   it to XLEN bits, optionally adds the PC, and carries the result through
//   STAGES elastic register stages (val/rdy handshake, collapsing bubbles).
//   Parameters:
//     XLEN   - datapath width of pc/imm/target (32 or 64)
//     STAGES - number of register stages (1..4) = latency in cycles
//   Ports:
//     clk   - clock, all state changes on the rising edge
//     rst   - synchronous active-high reset (clears valids and payloads)
//     flush - synchronous squash of every in-flight entry and of any input
//             handshake in the same cycle
//     bus   - imm_gen_pipe_if slave: request in, result out
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    // Payload layout: {imm, target, err, misalign}
    localparam int PW = 2 * XLEN + 2;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_J = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_c;
    logic [XLEN-1:0] target_c;
    logic            err_c;
    logic            misalign_c;
    logic [PW-1:0]   in_pay;

    // The opcode field does not influence the immediate.
    logic unused_opcode;
    assign unused_opcode = ^bus.inst[6:0];

    // Every format is first assembled as a 32-bit signed value; the final
    // widening to XLEN is a plain sign extension.
    always_comb begin
        imm32 = '0;
        err_c = 1'b0;
        case (bus.imm_type)
            IMM_I:   imm32 = {{20{bus.inst[31]}}, bus.inst[31:20]};
            IMM_S:   imm32 = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
            IMM_J:   imm32 = {{11{bus.inst[31]}}, bus.inst[31], bus.inst[19:12],
                              bus.inst[20], bus.inst[30:21], 1'b0};
            IMM_B:   imm32 = {{19{bus.inst[31]}}, bus.inst[31], bus.inst[7],
                              bus.inst[30:25], bus.inst[11:8], 1'b0};
            IMM_U:   imm32 = {bus.inst[31:12], 12'b0};
            default: err_c = 1'b1;  // illegal type: imm stays 0
        endcase
        imm_c      = XLEN'($signed(imm32));
        // Modulo-2^XLEN add; an illegal type yields pc (or 0) since imm_c=0.
        target_c   = bus.pc_rel ? (bus.pc + imm_c) : imm_c;
        misalign_c = ((bus.imm_type == IMM_J) || (bus.imm_type == IMM_B)) &&
                     bus.pc_rel && (target_c[1:0] != 2'b00);
    end

    assign in_pay = {imm_c, target_c, err_c, misalign_c};

    // ld[k]: stage k captures on this edge. ld[STAGES] is the consumer's
    // acceptance, so the ready chain runs combinationally from out_rdy
    // back to in_rdy.
    logic [STAGES:0]   ld;
    logic [STAGES-1:0] stage_val;
    logic [PW-1:0]     stage_pay [STAGES];

    always_comb begin
        ld         = '0;
        ld[STAGES] = bus.out_rdy;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ld[k] = !stage_val[k] || ld[k + 1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic          val_reg;
            logic [PW-1:0] pay_reg;
            logic          src_val;
            logic [PW-1:0] src_pay;

            if (gi == 0) begin : g_src_in
                assign src_val = bus.in_val;
                assign src_pay = in_pay;
            end else begin : g_src_prev
                assign src_val = stage_val[gi - 1];
                assign src_pay = stage_pay[gi - 1];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    val_reg <= 1'b0;
                    pay_reg <= '0;
                end else if (flush) begin
                    val_reg <= 1'b0;
                end else if (ld[gi]) begin
                    val_reg <= src_val;
                    // Bubbles move without disturbing the held payload.
                    if (src_val) begin
                        pay_reg <= src_pay;
                    end
                end
            end

            assign stage_val[gi] = val_reg;
            assign stage_pay[gi] = pay_reg;
        end
    endgenerate

    // flush deliberately does not gate in_rdy; the squash happens in the
    // stage registers instead.
    assign bus.in_rdy  = ld[0];
    assign bus.out_val = stage_val[STAGES - 1];
    assign {bus.imm, bus.target, bus.err, bus.misalign} = stage_pay[STAGES - 1];
endmodule
